// File: rtl/fetch_inst_buffer_if.sv
// Bundle between fetch, the instruction buffer and the decoder.
// The master side is fetch/decode; the slave side is the buffer itself.
interface fetch_inst_buffer_if #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic                  flush;
  logic [1:0]            fetch_valid;
  logic [1:0][31:0]      fetch_pc;
  logic [1:0][31:0]      fetch_inst;
  logic [1:0]            fetch_pretaken;
  logic [1:0][31:0]      fetch_pre_addr;
  logic [1:0][1:0]       fetch_is_exception;
  logic [1:0][1:0][6:0]  fetch_exception_cause;
  logic                  buffer_full;
  logic                  get_data_req;
  logic [1:0]            out_valid;
  logic [1:0][31:0]      out_pc;
  logic [1:0][31:0]      out_inst;
  logic [1:0]            out_pretaken;
  logic [1:0][31:0]      out_pre_addr;
  logic [1:0][1:0]       out_is_exception;
  logic [1:0][1:0][6:0]  out_exception_cause;
  logic [PTR_W:0]        buffer_count;

  modport master (
    output flush, fetch_valid, fetch_pc, fetch_inst, fetch_pretaken, fetch_pre_addr,
           fetch_is_exception, fetch_exception_cause, get_data_req,
    input  buffer_full, out_valid, out_pc, out_inst, out_pretaken, out_pre_addr,
           out_is_exception, out_exception_cause, buffer_count
  );

  modport slave (
    input  flush, fetch_valid, fetch_pc, fetch_inst, fetch_pretaken, fetch_pre_addr,
           fetch_is_exception, fetch_exception_cause, get_data_req,
    output buffer_full, out_valid, out_pc, out_inst, out_pretaken, out_pre_addr,
           out_is_exception, out_exception_cause, buffer_count
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// Dual-lane compacting instruction queue between fetch and decode.
// Delivers the two oldest entries as a registered one-cycle packet per request.
module fetch_inst_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  fetch_inst_buffer_if.slave  bus
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             pretaken;
    logic [31:0]      pre_addr;
    logic [1:0]       is_exception;
    logic [1:0][6:0]  exception_cause;
  } entry_t;

  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_TWO     = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   FULL_THRESH = (PTR_W+1)'(DEPTH-2);

  entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;
  logic [1:0]        out_valid_r;
  entry_t            out0_r;
  entry_t            out1_r;

  entry_t            lane0_s;
  entry_t            lane1_s;
  logic              full_s;
  logic              en_s;
  logic [1:0]        lane_valid_s;
  logic [1:0]        enq_n_s;
  logic [1:0]        deq_n_s;
  logic              wr0_en_s;
  logic              wr1_en_s;
  logic [PTR_W-1:0]  wr0_idx_s;
  logic [PTR_W-1:0]  wr1_idx_s;
  entry_t            wr0_data_s;
  entry_t            wr1_data_s;

  assign lane0_s = {bus.fetch_pc[0], bus.fetch_inst[0], bus.fetch_pretaken[0],
                    bus.fetch_pre_addr[0], bus.fetch_is_exception[0], bus.fetch_exception_cause[0]};
  assign lane1_s = {bus.fetch_pc[1], bus.fetch_inst[1], bus.fetch_pretaken[1],
                    bus.fetch_pre_addr[1], bus.fetch_is_exception[1], bus.fetch_exception_cause[1]};

  // Enqueue/dequeue amounts and compacted write ports
  always_comb begin
    full_s       = (count_r > FULL_THRESH);
    en_s         = !full_s && !bus.flush;
    // A taken prediction in lane 0 makes lane 1 wrong-path
    lane_valid_s = en_s ? {bus.fetch_valid[1] && !(bus.fetch_valid[0] && bus.fetch_pretaken[0]),
                           bus.fetch_valid[0]} : 2'b00;
    enq_n_s      = {1'b0, lane_valid_s[0]} + {1'b0, lane_valid_s[1]};
    if (bus.get_data_req && !bus.flush) begin
      deq_n_s = (count_r >= CNT_TWO) ? 2'd2 : count_r[1:0];
    end else begin
      deq_n_s = 2'd0;
    end
    wr0_en_s   = 1'b0;
    wr1_en_s   = 1'b0;
    wr0_idx_s  = tail_r;
    wr1_idx_s  = tail_r + PTR_ONE;
    wr0_data_s = lane0_s;
    wr1_data_s = lane1_s;
    case (lane_valid_s)
      2'b01: wr0_en_s = 1'b1;
      2'b10: begin
        wr0_en_s   = 1'b1;
        wr0_data_s = lane1_s;
      end
      2'b11: begin
        wr0_en_s = 1'b1;
        wr1_en_s = 1'b1;
      end
      default: begin
        wr0_en_s = 1'b0;
        wr1_en_s = 1'b0;
      end
    endcase
  end

  // Head/tail pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (bus.flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(deq_n_s);
      tail_r  <= tail_r + PTR_W'(enq_n_s);
      count_r <= count_r + (PTR_W+1)'(enq_n_s) - (PTR_W+1)'(deq_n_s);
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (wr0_en_s) mem_r[wr0_idx_s] <= wr0_data_s;
    if (wr1_en_s) mem_r[wr1_idx_s] <= wr1_data_s;
  end

  // Registered output packet; valid is a single-cycle pulse per request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 2'b00;
      out0_r      <= '0;
      out1_r      <= '0;
    end else if (bus.flush) begin
      out_valid_r <= 2'b00;
    end else begin
      out_valid_r <= {deq_n_s == 2'd2, deq_n_s != 2'd0};
      if (deq_n_s != 2'd0) out0_r <= mem_r[head_r];
      if (deq_n_s == 2'd2) out1_r <= mem_r[head_r + PTR_ONE];
    end
  end

  assign bus.buffer_full         = full_s;
  assign bus.buffer_count        = count_r;
  assign bus.out_valid           = out_valid_r;
  assign bus.out_pc              = {out1_r.pc, out0_r.pc};
  assign bus.out_inst            = {out1_r.inst, out0_r.inst};
  assign bus.out_pretaken        = {out1_r.pretaken, out0_r.pretaken};
  assign bus.out_pre_addr        = {out1_r.pre_addr, out0_r.pre_addr};
  assign bus.out_is_exception    = {out1_r.is_exception, out0_r.is_exception};
  assign bus.out_exception_cause = {out1_r.exception_cause, out0_r.exception_cause};

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed bench for fetch_inst_buffer: reset, fill/full, compaction, kill,
// wrap-around streaming with a PC-order scoreboard, and flush collision.
module tb_fetch_inst_buffer;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  fetch_inst_buffer_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();
  fetch_inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush                 = 1'b0;
    bus.fetch_valid           = 2'b00;
    bus.fetch_pc              = '0;
    bus.fetch_inst            = '0;
    bus.fetch_pretaken        = 2'b00;
    bus.fetch_pre_addr        = '0;
    bus.fetch_is_exception    = '0;
    bus.fetch_exception_cause = '0;
    bus.get_data_req          = 1'b0;
  endtask

  // Lane payload derived from pc so every field can be re-derived on output
  task automatic set_lane(input int lane, input logic [31:0] pc);
    bus.fetch_pc[lane]                 = pc;
    bus.fetch_inst[lane]               = ~pc;
    bus.fetch_pretaken[lane]           = 1'b0;
    bus.fetch_pre_addr[lane]           = pc + 32'h0000_0100;
    bus.fetch_is_exception[lane]       = pc[3:2];
    bus.fetch_exception_cause[lane][0] = pc[8:2];
    bus.fetch_exception_cause[lane][1] = ~pc[8:2];
  endtask

  function automatic logic [111:0] exp_lane(input logic [31:0] pc);
    logic [6:0] c0;
    logic [6:0] c1;
    c0 = pc[8:2];
    c1 = ~pc[8:2];
    return {pc, ~pc, pc + 32'h0000_0100, pc[3:2], c1, c0};
  endfunction

  task automatic push_pair(input logic [31:0] pc0);
    idle_inputs();
    set_lane(0, pc0);
    set_lane(1, pc0 + 32'd4);
    bus.fetch_valid = 2'b11;
    step();
  endtask

  task automatic do_flush();
    idle_inputs();
    bus.flush = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    vec_cnt++;
    if (bus.buffer_count !== 5'd0 || bus.buffer_full !== 1'b0 || bus.out_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_state: count=%0d full=%b valid=%b, required 0/0/00",
               bus.buffer_count, bus.buffer_full, bus.out_valid);
    end
    push_pair(BASE);
    push_pair(BASE + 32'd8);
    push_pair(BASE + 32'd16);
    idle_inputs();
    set_lane(0, BASE + 32'd24);
    bus.fetch_valid  = 2'b01;
    bus.get_data_req = 1'b1;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.buffer_count !== 5'd5 || bus.out_valid !== 2'b11 || bus.out_pc[0] !== BASE) begin
      err_cnt++;
      $display("FAIL pre_reset: count=%0d valid=%b pc0=%h, required 5/11/%h",
               bus.buffer_count, bus.out_valid, bus.out_pc[0], BASE);
    end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.buffer_count !== 5'd0 || bus.buffer_full !== 1'b0 || bus.out_valid !== 2'b00 ||
        bus.out_pc[0] !== 32'h0 || bus.out_pc[1] !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_reset: count=%0d full=%b valid=%b pc0=%h pc1=%h, required all zero",
               bus.buffer_count, bus.buffer_full, bus.out_valid, bus.out_pc[0], bus.out_pc[1]);
    end
    #1 rst = 1'b1;
    bus.get_data_req = 1'b1;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.out_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL req_after_reset: valid=%b, required 00", bus.out_valid);
    end
  endtask

  task automatic test_fill_full();
    int k;
    logic [1:0] exp_v;
    do_flush();
    for (int i = 0; i < 7; i++) push_pair(BASE + 32'(8 * i));
    vec_cnt++;
    if (bus.buffer_count !== 5'd14 || bus.buffer_full !== 1'b0) begin
      err_cnt++;
      $display("FAIL fill_14: count=%0d full=%b, required 14/0", bus.buffer_count, bus.buffer_full);
    end
    idle_inputs();
    set_lane(0, BASE + 32'd56);
    bus.fetch_valid = 2'b01;
    step();
    vec_cnt++;
    if (bus.buffer_count !== 5'd15 || bus.buffer_full !== 1'b1) begin
      err_cnt++;
      $display("FAIL fill_15: count=%0d full=%b, required 15/1", bus.buffer_count, bus.buffer_full);
    end
    push_pair(32'h1c00_0100);
    vec_cnt++;
    if (bus.buffer_count !== 5'd15) begin
      err_cnt++;
      $display("FAIL full_reject: count=%0d, required 15", bus.buffer_count);
    end
    // Full is still seen during a 2-entry dequeue, so this packet is dropped too
    idle_inputs();
    set_lane(0, 32'h1c00_0200);
    set_lane(1, 32'h1c00_0204);
    bus.fetch_valid  = 2'b11;
    bus.get_data_req = 1'b1;
    step();
    vec_cnt++;
    if (bus.buffer_count !== 5'd13 || bus.out_valid !== 2'b11 ||
        bus.out_pc[0] !== BASE || bus.out_pc[1] !== BASE + 32'd4) begin
      err_cnt++;
      $display("FAIL full_deq: count=%0d valid=%b pc0=%h pc1=%h, required 13/11/%h/%h",
               bus.buffer_count, bus.out_valid, bus.out_pc[0], bus.out_pc[1], BASE, BASE + 32'd4);
    end
    idle_inputs();
    bus.get_data_req = 1'b1;
    k = 2;
    for (int j = 0; j < 8; j++) begin
      exp_v = (k >= 15) ? 2'b00 : ((15 - k >= 2) ? 2'b11 : 2'b01);
      step();
      vec_cnt++;
      if (bus.out_valid !== exp_v ||
          (exp_v[0] && bus.out_pc[0] !== BASE + 32'(4 * k)) ||
          (exp_v[1] && bus.out_pc[1] !== BASE + 32'(4 * (k + 1)))) begin
        err_cnt++;
        $display("FAIL drain_%0d: valid=%b pc0=%h pc1=%h, required %b/%h/%h", j, bus.out_valid,
                 bus.out_pc[0], bus.out_pc[1], exp_v, BASE + 32'(4 * k), BASE + 32'(4 * (k + 1)));
      end
      k = k + (exp_v[1] ? 2 : (exp_v[0] ? 1 : 0));
    end
    idle_inputs();
    vec_cnt++;
    if (bus.buffer_count !== 5'd0) begin
      err_cnt++;
      $display("FAIL drain_empty: count=%0d, required 0", bus.buffer_count);
    end
  endtask

  task automatic test_compaction();
    do_flush();
    set_lane(1, 32'h1c00_0004);
    bus.fetch_pc[0]                 = 32'hdead_beef;
    bus.fetch_is_exception[1]       = 2'b10;
    bus.fetch_exception_cause[1][1] = 7'h2a;
    bus.fetch_valid                 = 2'b10;
    step();
    idle_inputs();
    step();
    bus.get_data_req = 1'b1;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.out_valid !== 2'b01 || bus.out_pc[0] !== 32'h1c00_0004 ||
        bus.out_is_exception[0] !== 2'b10 || bus.out_exception_cause[0][1] !== 7'h2a) begin
      err_cnt++;
      $display("FAIL compaction: valid=%b pc0=%h exc=%b cause1=%h, required 01/1c000004/10/2a",
               bus.out_valid, bus.out_pc[0], bus.out_is_exception[0], bus.out_exception_cause[0][1]);
    end
  endtask

  task automatic test_taken_kill();
    do_flush();
    set_lane(0, 32'h1c00_0010);
    set_lane(1, 32'h1c00_0014);
    bus.fetch_pretaken[0] = 1'b1;
    bus.fetch_valid       = 2'b11;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.buffer_count !== 5'd1) begin
      err_cnt++;
      $display("FAIL kill_count: count=%0d, required 1", bus.buffer_count);
    end
    bus.get_data_req = 1'b1;
    step();
    vec_cnt++;
    if (bus.out_valid !== 2'b01 || bus.out_pc[0] !== 32'h1c00_0010 || bus.out_pretaken[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL kill_out: valid=%b pc0=%h taken=%b, required 01/1c000010/1",
               bus.out_valid, bus.out_pc[0], bus.out_pretaken[0]);
    end
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.out_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL empty_req: valid=%b, required 00", bus.out_valid);
    end
  endtask

  task automatic test_stream_wrap();
    int issued = 0;
    int received = 0;
    int cyc = 0;
    logic [1:0] pat;
    logic accepted;
    logic [111:0] got;
    logic [111:0] exp;
    do_flush();
    while ((issued < 40 || received < 40) && cyc < 400) begin
      idle_inputs();
      pat = (issued < 40) ? 2'($urandom_range(0, 3)) : 2'b00;
      if (issued == 39 && pat == 2'b11) pat = 2'b01;
      if (pat[0]) set_lane(0, BASE + 32'(4 * issued));
      if (pat[1]) set_lane(1, BASE + 32'(4 * (issued + int'(pat[0]))));
      bus.fetch_valid  = pat;
      bus.get_data_req = (issued >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      accepted = !bus.buffer_full;
      step();
      cyc++;
      if (accepted) issued = issued + int'(pat[0]) + int'(pat[1]);
      vec_cnt++;
      if (bus.out_valid === 2'b10) begin
        err_cnt++;
        $display("FAIL stream_lane_order: valid=%b, required 00/01/11", bus.out_valid);
      end
      for (int l = 0; l < 2; l++) begin
        if (bus.out_valid[l] === 1'b1) begin
          got = {bus.out_pc[l], bus.out_inst[l], bus.out_pre_addr[l],
                 bus.out_is_exception[l], bus.out_exception_cause[l]};
          exp = exp_lane(BASE + 32'(4 * received));
          vec_cnt++;
          if (got !== exp || received >= 40) begin
            err_cnt++;
            $display("FAIL stream_entry_%0d: pc=%h payload=%h, required pc=%h payload=%h",
                     received, bus.out_pc[l], got, BASE + 32'(4 * received), exp);
          end
          received++;
        end
      end
    end
    idle_inputs();
    vec_cnt++;
    if (received !== 40 || bus.buffer_count !== 5'd0) begin
      err_cnt++;
      $display("FAIL stream_total: received=%0d count=%0d, required 40/0", received, bus.buffer_count);
    end
  endtask

  task automatic test_flush_collision();
    do_flush();
    push_pair(BASE);
    push_pair(BASE + 32'd8);
    push_pair(BASE + 32'd16);
    vec_cnt++;
    if (bus.buffer_count !== 5'd6) begin
      err_cnt++;
      $display("FAIL flush_pre: count=%0d, required 6", bus.buffer_count);
    end
    idle_inputs();
    set_lane(0, BASE + 32'd24);
    set_lane(1, BASE + 32'd28);
    bus.fetch_valid  = 2'b11;
    bus.get_data_req = 1'b1;
    bus.flush        = 1'b1;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.buffer_count !== 5'd0 || bus.out_valid !== 2'b00 || bus.buffer_full !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_collision: count=%0d valid=%b full=%b, required 0/00/0",
               bus.buffer_count, bus.out_valid, bus.buffer_full);
    end
    bus.get_data_req = 1'b1;
    step();
    idle_inputs();
    vec_cnt++;
    if (bus.out_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL flush_req: valid=%b, required 00", bus.out_valid);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #12 rst = 1'b1;
    test_reset();
    test_fill_full();
    test_compaction();
    test_taken_kill();
    test_stream_wrap();
    test_flush_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
